// File: rtl/rams_sp_bwe_wmode_512x16_logic.sv
// Single-port RAM with byte-lane write enables,
// selectable write mode and optional output register.
module rams_sp_bwe_wmode_512x16_logic #(
  parameter int    DATA_WIDTH = 16,
  parameter int    ADDR_WIDTH = 9,
  parameter int    BYTE_WIDTH = 8,
  parameter string WRITE_MODE = "WRITE_FIRST",
  parameter int    OUT_REG    = 0,
  parameter string RAM_STYLE  = "logic"
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           srst,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          di,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic                           dout_valid
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam bit WF = (WRITE_MODE == "WRITE_FIRST");
  localparam bit RF = (WRITE_MODE == "READ_FIRST");
  localparam bit NC = (WRITE_MODE == "NO_CHANGE");

  generate
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (!(WF || RF || NC)) begin : g_bad_mode
      $error("WRITE_MODE must be WRITE_FIRST, READ_FIRST or NO_CHANGE");
    end
    if (RAM_STYLE == "") begin : g_bad_style
      $error("RAM_STYLE must not be empty");
    end
  endgenerate

  (* ram_style = RAM_STYLE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] d1_q, d1_d;
  logic                  v1_q, v1_d;

  // Array write; blocked while reset is asserted, contents never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && en) begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) begin
          mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
            di[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign rd_word = mem[addr];

  // Word as it will look after this cycle's lane writes.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) begin
        merged[i*BYTE_WIDTH +: BYTE_WIDTH] =
          di[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Stage-1 next state: clear, read, or write-mode dependent result.
  always_comb begin
    d1_d = d1_q;
    v1_d = 1'b0;
    if (en) begin
      if (srst) begin
        d1_d = '0;
        v1_d = 1'b1;
      end else if (we == '0) begin
        d1_d = rd_word;
        v1_d = 1'b1;
      end else if (WF) begin
        d1_d = merged;
        v1_d = 1'b1;
      end else if (RF) begin
        d1_d = rd_word;
        v1_d = 1'b1;
      end
    end
  end

  // Stage-1 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      d1_q <= d1_d;
      v1_q <= v1_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] d2_q;
      logic                  v2_q;

      // Optional second stage; only captures qualified data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d2_q <= '0;
          v2_q <= 1'b0;
        end else begin
          if (v1_q) d2_q <= d1_q;
          v2_q <= v1_q;
        end
      end

      assign dout       = d2_q;
      assign dout_valid = v2_q;
    end else begin : g_no_out_reg
      assign dout       = d1_q;
      assign dout_valid = v1_q;
    end
  endgenerate

endmodule
